// File: rtl/myproject_acc_pkg.sv
// Shared types and constants for the convolution MAC accumulator stage.
// Helper functions derive the rounding offset and saturation limits from the widths.
package myproject_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_t;

    localparam int DEF_PROD_WIDTH = 31;
    localparam int DEF_ACC_WIDTH  = 36;
    localparam int DEF_N_TAPS     = 9;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_FRAC_SHIFT = 10;

    // Adding half an output LSB before the shift gives round-half-up.
    function automatic longint rnd_ofs(input int frac_shift);
        return 64'sd1 <<< (frac_shift - 1);
    endfunction

    function automatic longint sat_max(input int out_width);
        return (64'sd1 <<< (out_width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int out_width);
        return -(64'sd1 <<< (out_width - 1));
    endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational bias add, round-half-up, saturation and optional ReLU
// applied to the wide accumulated sum.
module myproject_round_sat
    import myproject_acc_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int RELU       = 0
) (
    input  logic signed [ACC_WIDTH:0]   sum,
    input  logic signed [OUT_WIDTH-1:0] bias,
    output logic signed [OUT_WIDTH-1:0] data,
    output logic                        sat
);

    localparam int WW = ACC_WIDTH + 1;
    localparam logic signed [WW-1:0] RND     = WW'(rnd_ofs(FRAC_SHIFT));
    localparam logic signed [WW-1:0] SAT_MAX = WW'(sat_max(OUT_WIDTH));
    localparam logic signed [WW-1:0] SAT_MIN = WW'(sat_min(OUT_WIDTH));

    logic signed [WW-1:0] bias_sh;
    logic signed [WW-1:0] r;

    always_comb begin
        bias_sh = WW'(bias) <<< FRAC_SHIFT;
        r       = (sum + bias_sh + RND) >>> FRAC_SHIFT;
        sat     = 1'b0;
        data    = r[OUT_WIDTH-1:0];
        if (r > SAT_MAX) begin
            data = SAT_MAX[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (r < SAT_MIN) begin
            data = SAT_MIN[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end
        // ReLU clamps after saturation and leaves the saturation flag alone.
        if ((RELU != 0) && data[OUT_WIDTH-1]) begin
            data = '0;
        end
    end

endmodule

// File: rtl/myproject_conv_mac_acc.sv
// Reduces each group of N_TAPS signed products to one biased, rounded,
// saturated output; valid/ready on both the product and result sides.
//
//   state   | meaning
//   IDLE    | waiting for the first tap of a group (acc, cnt are zero)
//   ACC     | accumulating taps 2..N_TAPS
//   HOLD    | result registered, waiting for out_ready; no taps accepted
module myproject_conv_mac_acc
    import myproject_acc_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int N_TAPS     = DEF_N_TAPS,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int RELU       = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [OUT_WIDTH-1:0]  bias,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat
);

    localparam int CNT_W = $clog2(N_TAPS + 1);
    localparam int WW    = ACC_WIDTH + 1;

    acc_state_t state, state_next;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]            cnt;
    logic                        accept;
    logic                        last_tap;
    logic signed [WW-1:0]        sum;
    logic signed [OUT_WIDTH-1:0] rs_data;
    logic                        rs_sat;

    // acc is zero in IDLE, so the same sum serves the first and later taps.
    assign sum      = WW'(acc) + WW'($signed(prod_data));
    assign last_tap = (cnt == CNT_W'(N_TAPS - 1));

    myproject_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT),
        .RELU       (RELU)
    ) u_round_sat (
        .sum  (sum),
        .bias ($signed(bias)),
        .data (rs_data),
        .sat  (rs_sat)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        prod_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE, ST_ACC: begin
                prod_ready = 1'b1;
                accept     = prod_valid;
                if (accept) begin
                    state_next = last_tap ? ST_HOLD : ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (accept) begin
            acc <= sum[ACC_WIDTH-1:0];
            cnt <= cnt + CNT_W'(1);
            if (last_tap) begin
                out_data  <= rs_data;
                out_sat   <= rs_sat;
                out_valid <= 1'b1;
            end
        end else if ((state == ST_HOLD) && out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_myproject_conv_mac_acc.sv
// Bench for the MAC accumulator: directed table, backpressure/reset sequences,
// and randomized groups checked against an arithmetic reference model.
module tb_myproject_conv_mac_acc;

    localparam int NT = 9;
    localparam int FS = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [30:0] prod_data;
    logic        prod_valid;
    logic [15:0] bias;
    logic        out_ready;

    logic        prod_ready, out_valid, out_sat;
    logic [15:0] out_data;
    logic        prod_ready_r, out_valid_r, out_sat_r;
    logic [15:0] out_data_r;

    always #5 clk = ~clk;

    myproject_conv_mac_acc dut (
        .ap_clk     (clk),
        .ap_rst     (rst),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .bias       (bias),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sat    (out_sat)
    );

    myproject_conv_mac_acc #(.RELU(1)) dut_relu (
        .ap_clk     (clk),
        .ap_rst     (rst),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready_r),
        .bias       (bias),
        .out_data   (out_data_r),
        .out_valid  (out_valid_r),
        .out_ready  (out_ready),
        .out_sat    (out_sat_r)
    );

    typedef struct {
        int data;
        bit sat;
        int relu_data;
    } exp_t;

    typedef struct {
        int p[NT];
        int b;
        int e_data;
        bit e_sat;
        int e_relu;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    int   n_groups = 0;
    int   n_results = 0;
    int   rdy_mode = 2;   // 0: always ready, 1: random, 2: driven by the main sequence
    bit   gaps = 0;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic longint floor_div(input longint t, input longint d);
        if (t >= 0) return t / d;
        return -((-t + d - 1) / d);
    endfunction

    function automatic exp_t model(input longint s, input int b);
        exp_t   e;
        longint r;
        r = floor_div(s + longint'(b) * 1024 + 512, 1024);
        e.sat = 1'b0;
        if (r > 32767) begin
            r = 32767;
            e.sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            e.sat = 1'b1;
        end
        e.data      = int'(r);
        e.relu_data = (r < 0) ? 0 : int'(r);
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic put_tap(input int p, output bit pre_valid);
        int n;
        pre_valid  = out_valid;
        prod_data  = p[30:0];
        prod_valid = 1'b1;
        n = 0;
        while (prod_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("prod_ready_timeout", 0, 1);
        pre_valid = out_valid;
        @(negedge clk);
        prod_valid = 1'b0;
    endtask

    task automatic send_group(input int p[NT], input int b, output bit pre_valid);
        longint s;
        bit     pv;
        s = 0;
        for (int i = 0; i < NT; i++) s += p[i];
        bias = b[15:0];
        expq.push_back(model(s, b));
        n_groups++;
        pv = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            put_tap(p[i], pv);
        end
        pre_valid = pv;
    endtask

    // Result monitor and out_ready driver, sampled just after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("mon_data", $signed(out_data), expq[0].data);
                    chk("mon_sat", out_sat, expq[0].sat);
                    chk("mon_relu_valid", out_valid_r, 1);
                    chk("mon_relu_data", $signed(out_data_r), expq[0].relu_data);
                    chk("mon_relu_sat", out_sat_r, expq[0].sat);
                end
            end
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 9) < 7);
            if (out_valid && out_ready && expq.size() > 0) begin
                void'(expq.pop_front());
                n_results++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[12];
    int   grp[NT];
    bit   pv;
    int   n;

    initial begin
        rst = 1'b1; prod_valid = 1'b0; prod_data = '0; bias = '0; out_ready = 1'b0;

        for (int i = 0; i < 12; i++) begin
            tbl[i].p = '{default: 0};
            tbl[i].b = 0;
        end
        tbl[0].p = '{default: 1024};            tbl[0].e_data = 9;      tbl[0].e_sat = 0; tbl[0].e_relu = 9;
        tbl[1].p[0] = -1000; tbl[1].p[4] = -300; tbl[1].p[8] = -236;
                                                tbl[1].e_data = -1;     tbl[1].e_sat = 0; tbl[1].e_relu = 0;
        tbl[2].p[1] = 500; tbl[2].p[5] = 500; tbl[2].p[7] = 536;
                                                tbl[2].e_data = 2;      tbl[2].e_sat = 0; tbl[2].e_relu = 2;
        tbl[3].p = '{default: 536870912};       tbl[3].e_data = 32767;  tbl[3].e_sat = 1; tbl[3].e_relu = 32767;
        tbl[4].p = '{default: -536838144};      tbl[4].b = -32768;
                                                tbl[4].e_data = -32768; tbl[4].e_sat = 1; tbl[4].e_relu = 0;
        tbl[5].p = '{default: 1024};            tbl[5].b = 5;
                                                tbl[5].e_data = 14;     tbl[5].e_sat = 0; tbl[5].e_relu = 14;
        tbl[6].p[0] = 511;                      tbl[6].e_data = 0;      tbl[6].e_sat = 0; tbl[6].e_relu = 0;
        tbl[7].p[0] = -513;                     tbl[7].e_data = -1;     tbl[7].e_sat = 0; tbl[7].e_relu = 0;
        tbl[8].p[0] = 33553408;                 tbl[8].e_data = 32767;  tbl[8].e_sat = 0; tbl[8].e_relu = 32767;
        tbl[9].p[0] = 33554432;                 tbl[9].e_data = 32767;  tbl[9].e_sat = 1; tbl[9].e_relu = 32767;
        tbl[10].p[0] = -33554432;               tbl[10].e_data = -32768; tbl[10].e_sat = 0; tbl[10].e_relu = 0;
        tbl[11].p[0] = -33555456;               tbl[11].e_data = -32768; tbl[11].e_sat = 1; tbl[11].e_relu = 0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_prod_ready", prod_ready, 1);
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            send_group(tbl[i].p, tbl[i].b, pv);
            chk("tbl_pre_valid", pv, 0);
            chk("tbl_valid_latency", out_valid, 1);
            chk("tbl_data", $signed(out_data), tbl[i].e_data);
            chk("tbl_sat", out_sat, tbl[i].e_sat);
            chk("tbl_relu_data", $signed(out_data_r), tbl[i].e_relu);
            chk("tbl_relu_sat", out_sat_r, tbl[i].e_sat);
        end

        // Backpressure: result held for five cycles while a stray product is offered.
        @(negedge clk);
        rdy_mode = 2;
        out_ready = 1'b0;
        grp = '{default: 1024};
        send_group(grp, 5, pv);
        for (int i = 0; i < 5; i++) begin
            prod_valid = 1'b1;
            prod_data  = 31'd12345;
            chk("hold_prod_ready", prod_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", $signed(out_data), 14);
            @(negedge clk);
        end
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_prod_ready", prod_ready, 1);
        rdy_mode = 0;
        send_group(grp, 0, pv);
        chk("after_hold_data", $signed(out_data), 9);

        // Reset in the middle of a group discards the partial sum.
        @(negedge clk);
        for (int i = 0; i < 4; i++) put_tap(1024, pv);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_sat", out_sat, 0);
        chk("midrst_prod_ready", prod_ready, 1);
        chk("midrst_relu_prod_ready", prod_ready_r, 1);
        rst = 1'b0;
        send_group(grp, 0, pv);
        chk("midrst_group_data", $signed(out_data), 9);

        // Randomized groups with producer gaps and random consumer stalls.
        rdy_mode = 1;
        gaps = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            for (int i = 0; i < NT; i++) begin
                int k;
                int mag;
                k = int'($urandom_range(6, 30));
                mag = int'($urandom_range(0, (32'd1 << k) - 1));
                grp[i] = ($urandom_range(0, 1) == 1) ? -mag : mag;
            end
            send_group(grp, int'($urandom_range(0, 65535)) - 32768, pv);
        end
        gaps = 1'b0;
        rdy_mode = 0;
        n = 0;
        while (expq.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_queue_empty", expq.size(), 0);
        chk("group_count", n_results, n_groups);
        chk("final_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
